bf16_mac_sched_44: RTL

Round-robin scheduler that shares one pipelined BF16 multiply-accumulate datapath among `NUM_REQ` requesters. It sits between the requesters and the MAC unit. For each granted job it clears the accumulator, issues one operand pair per cycle via an element index, counts returning accumulations, captures the final BF16 sum and pulses done to the owner. A drain watchdog converts a stalled MAC into a flagged NaN result.

---
 rtl/bf16_mac_sched_44_pkg.sv | 26 ++
 rtl/bf16_mac_sched_44_arb.sv | 30 +++
 rtl/bf16_mac_sched_44.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/bf16_mac_sched_44_pkg.sv
// Shared types and constants for the BF16 MAC scheduler: FSM state encoding,
// BF16 special values, default latencies and a saturating counter helper.
package bf16_sched_pkg_44;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_ISSUE = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam logic [15:0] BF16_ZERO = 16'h0000;
  localparam logic [15:0] BF16_QNAN = 16'h7FC0;

  localparam int unsigned DEF_NUM_REQ      = 4;
  localparam int unsigned DEF_NUM_ELEMENTS = 12;
  localparam int unsigned DEF_MUL_LAT      = 3;
  localparam int unsigned DEF_ACC_LAT      = 1;
  localparam int unsigned DEF_WDOG         = 32;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/bf16_mac_sched_44_arb.sv
// Combinational round-robin pick: first requesting bit at or above rr_ptr,
// wrapping around; the pointer itself is owned by the scheduler.
module rr_arbiter_44 #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PW      = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      rr_ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PW-1:0]      gnt_idx,
  output logic               any
);

  always_comb begin
    int unsigned k;
    k       = 0;
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      k = (32'(rr_ptr) + i) % NUM_REQ;
      if (!any && req[k]) begin
        gnt[k]  = 1'b1;
        gnt_idx = PW'(k);
        any     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bf16_mac_sched_44.sv
// Round-robin scheduler sharing one pipelined BF16 MAC among NUM_REQ requesters:
// clear, issue one pair per cycle, count returns, capture the sum, pulse done.
module bf16_mac_sched_44
  import bf16_sched_pkg_44::*;
#(
  parameter int unsigned NUM_REQ      = DEF_NUM_REQ,
  parameter int unsigned NUM_ELEMENTS = DEF_NUM_ELEMENTS,
  parameter int unsigned MUL_LAT      = DEF_MUL_LAT,
  parameter int unsigned ACC_LAT      = DEF_ACC_LAT,
  parameter int unsigned WDOG         = DEF_WDOG
) (
  input  logic                 clk_44,
  input  logic                 rst_44,
  input  logic [NUM_REQ-1:0]   req_44,
  input  logic [NUM_REQ*4-1:0] len_44,
  output logic [NUM_REQ-1:0]   grant_44,
  output logic [3:0]           elem_idx_44,
  output logic                 mac_clear_44,
  output logic                 mac_valid_in_44,
  input  logic                 mac_valid_out_44,
  input  logic [15:0]          mac_result_44,
  output logic [15:0]          result_44,
  output logic [NUM_REQ-1:0]   done_44,
  output logic                 busy_44,
  output logic                 err_44,
  output logic [7:0]           debug_cycle_count_44
);

  localparam int unsigned PW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned WW     = $clog2(WDOG + 1);
  localparam logic [3:0]  MAXLEN = 4'(NUM_ELEMENTS);

  // A drain that normally lasts the MAC latency must fit inside the watchdog window.
  if (MUL_LAT + ACC_LAT >= WDOG) begin : g_cfg_check
    $error("bf16_mac_sched_44: WDOG must exceed MUL_LAT+ACC_LAT");
  end

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [PW-1:0]      gidx_q, gidx_d, rr_ptr_q, rr_ptr_d;
  logic [3:0]         len_q, len_d, issue_cnt_q, issue_cnt_d, ret_cnt_q, ret_cnt_d;
  logic [7:0]         cyc_q, cyc_d;
  logic [WW-1:0]      wdog_q, wdog_d;
  logic [15:0]        result_q, result_d;
  logic               err_q, err_d;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [PW-1:0]      arb_idx;
  logic               arb_any;
  logic [3:0]         len_sel, len_clamped;
  logic               last_ret;

  rr_arbiter_44 #(.NUM_REQ(NUM_REQ), .PW(PW)) u_arb (
    .req     (req_44),
    .rr_ptr  (rr_ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .any     (arb_any)
  );

  always_comb begin
    len_sel = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) len_sel = len_44[4*i +: 4];
    end
    len_clamped = (len_sel > MAXLEN) ? MAXLEN : len_sel;
  end

  assign last_ret = mac_valid_out_44 && (ret_cnt_q + 4'd1 == len_q);

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    gidx_d      = gidx_q;
    rr_ptr_d    = rr_ptr_q;
    len_d       = len_q;
    issue_cnt_d = issue_cnt_q;
    ret_cnt_d   = ret_cnt_q;
    cyc_d       = cyc_q;
    wdog_d      = wdog_q;
    result_d    = result_q;
    err_d       = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          grant_d = arb_gnt;
          gidx_d  = arb_idx;
          len_d   = len_clamped;
          err_d   = 1'b0;
          cyc_d   = '0;
          if (len_clamped == 4'd0) begin
            result_d = BF16_ZERO;
            state_d  = ST_DONE;
          end else begin
            state_d  = ST_CLEAR;
          end
        end
      end
      ST_CLEAR: begin
        issue_cnt_d = '0;
        ret_cnt_d   = '0;
        wdog_d      = '0;
        cyc_d       = sat_inc8(cyc_q);
        state_d     = ST_ISSUE;
      end
      ST_ISSUE: begin
        issue_cnt_d = issue_cnt_q + 4'd1;
        cyc_d       = sat_inc8(cyc_q);
        if (mac_valid_out_44) ret_cnt_d = ret_cnt_q + 4'd1;
        if (last_ret) begin
          result_d = mac_result_44;
          state_d  = ST_DONE;
        end else if (issue_cnt_q == len_q - 4'd1) begin
          state_d  = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        cyc_d  = sat_inc8(cyc_q);
        wdog_d = wdog_q + 1'b1;
        if (mac_valid_out_44) ret_cnt_d = ret_cnt_q + 4'd1;
        if (last_ret) begin
          result_d = mac_result_44;
          state_d  = ST_DONE;
        end else if (wdog_q == WW'(WDOG - 1)) begin
          result_d = BF16_QNAN;
          err_d    = 1'b1;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        grant_d  = '0;
        rr_ptr_d = (gidx_q == PW'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_44 or posedge rst_44) begin
    if (rst_44) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      gidx_q      <= '0;
      rr_ptr_q    <= '0;
      len_q       <= '0;
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
      cyc_q       <= '0;
      wdog_q      <= '0;
      result_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      gidx_q      <= gidx_d;
      rr_ptr_q    <= rr_ptr_d;
      len_q       <= len_d;
      issue_cnt_q <= issue_cnt_d;
      ret_cnt_q   <= ret_cnt_d;
      cyc_q       <= cyc_d;
      wdog_q      <= wdog_d;
      result_q    <= result_d;
      err_q       <= err_d;
    end
  end

  assign grant_44             = grant_q;
  assign elem_idx_44          = (state_q == ST_ISSUE) ? issue_cnt_q : 4'd0;
  assign mac_clear_44         = (state_q == ST_CLEAR);
  assign mac_valid_in_44      = (state_q == ST_ISSUE);
  assign result_44            = result_q;
  assign done_44              = (state_q == ST_DONE) ? grant_q : '0;
  assign busy_44              = (state_q != ST_IDLE);
  assign err_44               = err_q;
  assign debug_cycle_count_44 = cyc_q;

endmodule
